// File: rtl/wb_simple_master_if.sv
// Classic Wishbone bus bundle between a single initiator and its slaves.
interface wb_simple_master_if;
  logic [31:0] p_wb_ADR_O;
  logic [31:0] p_wb_DAT_O;
  logic [31:0] p_wb_DAT_I;
  logic [3:0]  p_wb_SEL_O;
  logic        p_wb_WE_O;
  logic        p_wb_CYC_O;
  logic        p_wb_STB_O;
  logic        p_wb_LOCK_O;
  logic        p_wb_ACK_I;
  logic        p_wb_ERR_I;
  logic        p_wb_RTY_I;

  modport master (
    output p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O,
           p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
    input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
  );

  modport slave (
    input  p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O,
           p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
    output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
  );
endinterface

// File: rtl/wb_simple_master.sv
// Single-transfer Wishbone initiator with per-attempt timeout, bounded
// retry on RTY and a status code returned with every completed transfer.
module wb_simple_master #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_dat,
  wb_simple_master_if.master wb
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // A zero-retry build still needs a one-bit counter to keep widths legal.
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2,
    RSP_RETRY   = 2'd3
  } rsp_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;

  // State and datapath registers; reset drops CYC/STB at once via state.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      tcnt_q       <= '0;
      rcnt_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_dat_q    <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      tcnt_q       <= tcnt_d;
      rcnt_q       <= rcnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_dat_q    <= rsp_dat_d;
    end
  end

  // Next-state, counters and response; terminations resolve ERR > ACK > RTY > timeout.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    tcnt_d       = tcnt_q;
    rcnt_d       = rcnt_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_dat_d    = rsp_dat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          tcnt_d  = '0;
          rcnt_d  = '0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        if (wb.p_wb_ERR_I) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_ERR;
          rsp_dat_d    = '0;
          state_d      = ST_IDLE;
        end else if (wb.p_wb_ACK_I) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
          rsp_dat_d    = we_q ? '0 : wb.p_wb_DAT_I;
          state_d      = ST_IDLE;
        end else if (wb.p_wb_RTY_I) begin
          if (rcnt_q < RW'(MAX_RETRY)) begin
            rcnt_d  = rcnt_q + 1'b1;
            tcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_RETRY;
            rsp_dat_d    = '0;
            state_d      = ST_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_TIMEOUT;
            rsp_dat_d    = '0;
            state_d      = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        state_d = ST_BUS;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus and handshake outputs are decoded from the registered state only.
  always_comb begin
    cmd_ready      = (state_q == ST_IDLE);
    wb.p_wb_CYC_O  = (state_q == ST_BUS);
    wb.p_wb_STB_O  = (state_q == ST_BUS);
    wb.p_wb_LOCK_O = 1'b0;
    wb.p_wb_ADR_O  = adr_q;
    wb.p_wb_DAT_O  = dat_q;
    wb.p_wb_SEL_O  = sel_q;
    wb.p_wb_WE_O   = we_q;
    rsp_valid      = rsp_valid_q;
    rsp_status     = rsp_status_q;
    rsp_dat        = rsp_dat_q;
  end

endmodule

// File: doc/wb_simple_master.md
# wb_simple_master

Single-transfer Wishbone initiator that turns one-shot write/read commands from a local controller into classic Wishbone cycles on the shared bus. It sits on the bus opposite the memory-mapped slaves, including the register-bank slave at 0xB0000000, and drives their control and data registers. It adds timeout, bounded retry on RTY and a status code per transfer, so the controller never hangs on an unresponsive slave.

## Interface
- TIMEOUT, 16: bus cycles to wait for ACK/ERR/RTY per attempt (must be >= 1).
- MAX_RETRY, 3: RTY-triggered re-attempts allowed after the first attempt (0 = no retry).
- p_clk  in  1  bus clock; all logic rising-edge.
- p_resetn  in  1  one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge with cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data (ignored for reads).
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_status  out  2  0 OK, 1 ERR, 2 TIMEOUT, 3 RETRY_EXHAUSTED; valid with rsp_valid.
- rsp_dat  out  32  read data captured on ACK; 0 for writes and failures.
- p_wb_ADR_O  out  32  registered cmd_adr.
- p_wb_DAT_O  out  32  registered cmd_dat.
- p_wb_DAT_I  in  32  read data from slave.
- p_wb_SEL_O  out  4  registered cmd_sel.
- p_wb_WE_O  out  1  registered cmd_we.
- p_wb_CYC_O  out  1  cycle valid.
- p_wb_STB_O  out  1  strobe.
- p_wb_LOCK_O  out  1  tied 0.
- p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I  in  1 each  termination inputs.

## Operation
- States: IDLE, BUS, GAP.
- IDLE: cmd_ready = 1, CYC = STB = 0. On accept: latch ADR/DAT/SEL/WE, clear timeout counter and retry counter, go to BUS.
- BUS: CYC = STB = 1; ADR/DAT/SEL/WE are held stable. Termination inputs are sampled on every edge. Priority: ERR > ACK > RTY > timeout.
  - ERR: respond ERR, go to IDLE.
  - ACK: respond OK; if a read, rsp_dat = p_wb_DAT_I. Go to IDLE.
  - RTY: if retry count < MAX_RETRY, increment it, clear the timeout counter and go to GAP. Otherwise respond RETRY_EXHAUSTED and go to IDLE.
  - No termination: increment the timeout counter. When it reaches TIMEOUT (TIMEOUT cycles in BUS on this attempt), respond TIMEOUT and go to IDLE.
- GAP: CYC = STB = 0 for exactly one cycle, then BUS with the same latched ADR/DAT/SEL/WE.
- Responding means rsp_valid = 1 in the cycle after the terminating edge, together with the IDLE state. rsp_status and rsp_dat hold their values until the next response.
- Termination inputs seen in IDLE or GAP are ignored.
- Timeout counter is $clog2(TIMEOUT+1) bits. Retry counter is $clog2(MAX_RETRY+1) bits. Neither counter wraps: both clear on accept.
- Reset values: state IDLE, cmd_ready 1 after reset release, CYC/STB/WE/LOCK 0, ADR/DAT/SEL 0, rsp_valid 0, rsp_status 0, rsp_dat 0.

## Timing
- Accept at edge k → CYC/STB high during cycle k+1.
- Combinational-ACK slave: ACK is sampled at edge k+1. CYC/STB fall after k+1. rsp_valid is high in cycle k+2, as is cmd_ready.
- Minimum issue interval is 2 cycles per transfer. CYC/STB are never high in the cycle where rsp_valid is high.
- Each RTY adds 2 cycles: the RTY edge, then one GAP cycle.
- Timeout with TIMEOUT = 16: accept at k, CYC/STB high in cycles k+1..k+16, rsp_valid in cycle k+17 with status 2.
- Reset mid-transfer: CYC/STB drop asynchronously on p_resetn low. No response is issued and the command is lost.

## Test plan
- Write to 0xB0000004, data 0x12345678, sel 0xF, slave ACKs immediately → one-cycle CYC/STB pulse with correct ADR/DAT/WE=1; rsp_valid 2 cycles after accept; status 0.
- Read from 0xB0000010, slave returns 0xCAFEBABE with ACK after 3 wait cycles → rsp_dat 0xCAFEBABE, status 0, CYC high for 4 cycles.
- Slave asserts RTY on the first two attempts, then ACK (MAX_RETRY = 3) → two 1-cycle CYC gaps; address unchanged across attempts; status 0. With RTY held permanently → 4 attempts, then status 3.
- No slave response (TIMEOUT = 16) → CYC high exactly 16 cycles; status 2; rsp_dat 0. ACK and ERR in the same cycle → status 1.
- Back-to-back: cmd_valid held high with 4 queued writes → accepts spaced 2 cycles apart; 4 rsp_valid pulses, in order.
- p_resetn low while in BUS → CYC/STB/rsp_valid 0 immediately. After release: IDLE, cmd_ready 1, no spurious response.
